// File: rtl/dog_ram_rsp.sv
// rtl/dog_ram_rsp.sv - DoG RAM responder: ram0/ram1 fixed-latency reads, ram1 writes, ram0 preload
module dog_ram_rsp #(
  parameter int DEPTH  = 4096,
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid_in,
  input  logic [AW-1:0] ld_addr_in,
  input  logic [DW-1:0] ld_data_in,
  input  logic          ram0_rd_valid_in,
  input  logic [AW-1:0] ram0_rd_addr_in,
  input  logic          ram1_rd_valid_in,
  input  logic [AW-1:0] ram1_rd_addr_in,
  input  logic          ram1_wr_valid_in,
  input  logic [AW-1:0] ram1_wr_addr_in,
  input  logic [DW-1:0] ram1_wr_data_in,
  output logic          ram0_valid_out,
  output logic [DW-1:0] ram0_data_out,
  output logic          ram1_valid_out,
  output logic [DW-1:0] ram1_data_out,
  output logic [15:0]   wr_cnt_out,
  output logic          addr_err_out
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("dog_ram_rsp: RD_LAT must be in 1..4");
  end

  logic [DW-1:0] ram0 [DEPTH];
  logic [DW-1:0] ram1 [DEPTH];

  logic          ld_ok, r0_ok, r1_ok, w1_ok;
  logic [IW-1:0] ld_idx, r0_idx, r1_idx, w1_idx;
  logic          ld_we, w1_we;
  logic          any_err;
  logic [DW-1:0] r0_data, r1_data;

  logic          v0_pipe [RD_LAT];
  logic          v1_pipe [RD_LAT];
  logic [DW-1:0] d0_pipe [RD_LAT];
  logic [DW-1:0] d1_pipe [RD_LAT];

  assign ld_ok  = {1'b0, ld_addr_in}      < DEPTH_W;
  assign r0_ok  = {1'b0, ram0_rd_addr_in} < DEPTH_W;
  assign r1_ok  = {1'b0, ram1_rd_addr_in} < DEPTH_W;
  assign w1_ok  = {1'b0, ram1_wr_addr_in} < DEPTH_W;

  assign ld_idx = ld_addr_in[IW-1:0];
  assign r0_idx = ram0_rd_addr_in[IW-1:0];
  assign r1_idx = ram1_rd_addr_in[IW-1:0];
  assign w1_idx = ram1_wr_addr_in[IW-1:0];

  assign ld_we  = ld_valid_in && ld_ok;
  assign w1_we  = ram1_wr_valid_in && w1_ok;

  assign any_err = (ld_valid_in      && !ld_ok) ||
                   (ram0_rd_valid_in && !r0_ok) ||
                   (ram1_rd_valid_in && !r1_ok) ||
                   (ram1_wr_valid_in && !w1_ok);

  // Arrays carry no reset so contents survive it; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && ld_we) begin
      ram0[ld_idx] <= ld_data_in;
    end
    if (rst_n && w1_we) begin
      ram1[w1_idx] <= ram1_wr_data_in;
    end
  end

  // Write-first: a same-edge write to the read address is forwarded into the return path.
  always_comb begin
    r0_data = '0;
    r1_data = '0;
    if (r0_ok) begin
      r0_data = (ld_we && (ld_idx == r0_idx)) ? ld_data_in : ram0[r0_idx];
    end
    if (r1_ok) begin
      r1_data = (w1_we && (w1_idx == r1_idx)) ? ram1_wr_data_in : ram1[r1_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        v0_pipe[i] <= 1'b0;
        v1_pipe[i] <= 1'b0;
        d0_pipe[i] <= '0;
        d1_pipe[i] <= '0;
      end
    end else begin
      v0_pipe[0] <= ram0_rd_valid_in;
      v1_pipe[0] <= ram1_rd_valid_in;
      d0_pipe[0] <= ram0_rd_valid_in ? r0_data : '0;
      d1_pipe[0] <= ram1_rd_valid_in ? r1_data : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        v0_pipe[i] <= v0_pipe[i-1];
        v1_pipe[i] <= v1_pipe[i-1];
        d0_pipe[i] <= d0_pipe[i-1];
        d1_pipe[i] <= d1_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_out   <= '0;
      addr_err_out <= 1'b0;
    end else begin
      if (w1_we && (wr_cnt_out != 16'hFFFF)) begin
        wr_cnt_out <= wr_cnt_out + 16'd1;
      end
      if (any_err) begin
        addr_err_out <= 1'b1;
      end
    end
  end

  assign ram0_valid_out = v0_pipe[RD_LAT-1];
  assign ram1_valid_out = v1_pipe[RD_LAT-1];
  assign ram0_data_out  = d0_pipe[RD_LAT-1];
  assign ram1_data_out  = d1_pipe[RD_LAT-1];

endmodule
